ps2_cmd_scheduler: RTL and testbench

Host-side command sequencer for the PS/2 transceiver (ps2_receiver). It shares the single transmit path between two command requesters: req 0 for LED/lock-state updates and req 1 for init and typematic settings. For each command it sends the command byte, waits for ACK, optionally sends one parameter byte and waits for ACK again, with RESEND/timeout retry. Non-response received bytes are forwarded unchanged to the scan-code decoder.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_cmd_scheduler_if.sv | 38 +++
 rtl/ps2_rr_arbiter2.sv | 33 +++
 rtl/ps2_cmd_scheduler.sv | 135 +++++++++++++
 tb/tb_ps2_cmd_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// PS/2 command scheduler shared definitions:
// protocol byte values and the sequencer state encoding.
package ps2_pkg;

  localparam logic [7:0] ACK          = 8'hFA;
  localparam logic [7:0] RESEND       = 8'hFE;
  localparam logic [7:0] KBD_ERROR    = 8'hFC;
  localparam logic [7:0] SELF_TEST    = 8'hAA;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_CMD,
    S_WAIT_CMD_ACK,
    S_SEND_PARAM,
    S_WAIT_PARAM_ACK,
    S_FINISH
  } state_t;

  function automatic logic is_rsp(input logic [7:0] b);
    return (b == ACK) || (b == RESEND) || (b == KBD_ERROR);
  endfunction

endpackage

// File: rtl/ps2_cmd_scheduler_if.sv
// Requester, transceiver and scan-forward signals of the scheduler.
// master = scheduler side, slave = requesters/transceiver side.
interface ps2_cmd_scheduler_if;
  logic [1:0] req;
  logic [7:0] cmd0;
  logic [7:0] cmd1;
  logic [7:0] param0;
  logic [7:0] param1;
  logic       has_param0;
  logic       has_param1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       err;
  logic       ps2_write;
  logic [7:0] ps2_tx_data;
  logic       ps2_read;
  logic [7:0] ps2_rx_data;
  logic       ps2_busy;
  logic       scan_valid;
  logic [7:0] scan_data;
  logic       busy;

  modport master (
    input  req, cmd0, cmd1, param0, param1,
    input  has_param0, has_param1,
    input  ps2_read, ps2_rx_data, ps2_busy,
    output gnt, done, err, ps2_write, ps2_tx_data,
    output scan_valid, scan_data, busy
  );

  modport slave (
    output req, cmd0, cmd1, param0, param1,
    output has_param0, has_param1,
    output ps2_read, ps2_rx_data, ps2_busy,
    input  gnt, done, err, ps2_write, ps2_tx_data,
    input  scan_valid, scan_data, busy
  );
endinterface

// File: rtl/ps2_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant,
// registered last grant (resets to 1 so requester 0 wins first).
module ps2_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_last;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      unique case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (|o_gnt) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/ps2_cmd_scheduler.sv
// PS/2 host command scheduler: arbitrates two requesters onto the
// transmit path and runs the cmd/param ACK handshake with retry.
module ps2_cmd_scheduler #(
  parameter int ACK_TIMEOUT = 240000,
  parameter int MAX_RETRY   = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  ps2_cmd_scheduler_if.master bus
);
  import ps2_pkg::*;

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam int RT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [RT_W-1:0] RT_MAX = RT_W'(MAX_RETRY);

  state_t          r_state;
  state_t          w_next;
  logic [TO_W-1:0] r_cnt;
  logic [RT_W-1:0] r_retry;
  logic [7:0]      r_tx;
  logic [7:0]      r_param;
  logic            r_has_param;
  logic            r_owner;
  logic            r_err;
  logic            r_scan_v;
  logic [7:0]      r_scan_d;

  logic [1:0] w_gnt;
  logic       w_arb_en;
  logic       w_wait;
  logic       w_fa;
  logic       w_fc;
  logic       w_again;
  logic       w_can_retry;
  logic       w_retry;
  logic       w_send;
  logic       w_fwd;

  assign w_arb_en = rst_n && (r_state == S_IDLE);

  ps2_rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_arb_en),
    .i_req (bus.req),
    .o_gnt (w_gnt)
  );

  assign w_wait = (r_state == S_WAIT_CMD_ACK) ||
                  (r_state == S_WAIT_PARAM_ACK);
  assign w_fa = bus.ps2_read && (bus.ps2_rx_data == ACK);
  assign w_fc = bus.ps2_read && (bus.ps2_rx_data == KBD_ERROR);
  // ACK and error win over a coincident timeout expiry
  assign w_again = !w_fa && !w_fc &&
                   ((bus.ps2_read && (bus.ps2_rx_data == RESEND)) ||
                    (r_cnt == TO_LAST));
  assign w_can_retry = r_retry < RT_MAX;
  assign w_retry = w_wait && w_again && w_can_retry;
  assign w_send = ((r_state == S_SEND_CMD) ||
                   (r_state == S_SEND_PARAM)) && !bus.ps2_busy;
  assign w_fwd = bus.ps2_read &&
                 !(w_wait && is_rsp(bus.ps2_rx_data));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:       if (|w_gnt) w_next = S_SEND_CMD;
      S_SEND_CMD:   if (w_send) w_next = S_WAIT_CMD_ACK;
      S_SEND_PARAM: if (w_send) w_next = S_WAIT_PARAM_ACK;
      S_WAIT_CMD_ACK, S_WAIT_PARAM_ACK: begin
        unique case (1'b1)
          w_fa: w_next = ((r_state == S_WAIT_CMD_ACK) && r_has_param)
                         ? S_SEND_PARAM : S_FINISH;
          w_fc: w_next = S_FINISH;
          w_again: begin
            if (!w_can_retry)
              w_next = S_FINISH;
            else if (r_state == S_WAIT_CMD_ACK)
              w_next = S_SEND_CMD;
            else
              w_next = S_SEND_PARAM;
          end
          default: w_next = r_state;
        endcase
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_tx        <= '0;
      r_param     <= '0;
      r_has_param <= 1'b0;
      r_owner     <= 1'b0;
      r_err       <= 1'b0;
      r_scan_v    <= 1'b0;
      r_scan_d    <= '0;
    end else begin
      r_state  <= w_next;
      r_scan_v <= w_fwd;
      if (w_fwd) r_scan_d <= bus.ps2_rx_data;
      if (|w_gnt) begin
        r_owner     <= w_gnt[1];
        r_tx        <= w_gnt[1] ? bus.cmd1 : bus.cmd0;
        r_param     <= w_gnt[1] ? bus.param1 : bus.param0;
        r_has_param <= w_gnt[1] ? bus.has_param1 : bus.has_param0;
        r_retry     <= '0;
      end
      if (w_send) r_cnt <= '0;
      else if (w_wait) r_cnt <= r_cnt + 1'b1;
      if (w_next == S_SEND_PARAM && r_state == S_WAIT_CMD_ACK && w_fa)
        r_tx <= r_param;
      if (w_retry) r_retry <= r_retry + 1'b1;
      if (w_wait && w_next == S_FINISH) r_err <= !w_fa;
    end
  end

  assign bus.gnt         = w_gnt;
  assign bus.ps2_write   = w_send;
  assign bus.ps2_tx_data = r_tx;
  assign bus.done        = (r_state != S_FINISH) ? 2'b00 :
                           (r_owner ? 2'b10 : 2'b01);
  assign bus.err         = (r_state == S_FINISH) && r_err;
  assign bus.scan_valid  = r_scan_v;
  assign bus.scan_data   = r_scan_d;
  assign bus.busy        = r_state != S_IDLE;

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Bench for ps2_cmd_scheduler: scoreboards grants, writes, done/err
// and forwarded bytes against a scripted keyboard responder.
module tb_ps2_cmd_scheduler;
  import ps2_pkg::*;

  localparam int TO = 1000;

  typedef struct {
    int         dly;
    logic       en;
    logic [7:0] b;
    logic       pre;
    logic [7:0] pb;
  } rsp_t;

  logic clk;
  logic rst_n;

  ps2_cmd_scheduler_if bus();

  ps2_cmd_scheduler #(
    .ACK_TIMEOUT (TO),
    .MAX_RETRY   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tot = 0;
  int n_bad = 0;
  logic [7:0] wq[$];
  logic [7:0] sq[$];
  logic [1:0] gq[$];
  logic [2:0] dq[$];
  rsp_t rq[$];
  rsp_t pq[$];
  bit gap_chk = 0;
  int cyc = 0;
  int last_wr = -1;
  rsp_t tmp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic rsp_t mk(input int dly, input logic en,
                              input logic [7:0] b);
    rsp_t r;
    r.dly = dly;
    r.en  = en;
    r.b   = b;
    r.pre = 1'b0;
    r.pb  = 8'h00;
    return r;
  endfunction

  // monitor: pops expectations as the DUT produces events
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!gap_chk) last_wr = -1;
      if (bus.gnt != 2'b00) begin
        if (gq.size() > 0) chk("gnt", bus.gnt, gq.pop_front());
        else chk("gnt_unexp", gq.size(), 1);
      end
      if (bus.ps2_write) begin
        chk("wr_busy", bus.ps2_busy, 0);
        if (wq.size() > 0) chk("wr", bus.ps2_tx_data, wq.pop_front());
        else chk("wr_unexp", wq.size(), 1);
        if (gap_chk) begin
          if (last_wr >= 0) chk("wr_gap", cyc - last_wr, TO + 1);
          last_wr = cyc;
        end
        if (rq.size() > 0) pq.push_back(rq.pop_front());
      end
      if (bus.done != 2'b00) begin
        if (dq.size() > 0) chk("done", {bus.done, bus.err}, dq.pop_front());
        else chk("done_unexp", dq.size(), 1);
      end
      if (bus.scan_valid) begin
        if (sq.size() > 0) chk("scan", bus.scan_data, sq.pop_front());
        else chk("scan_unexp", sq.size(), 1);
      end
    end
  end

  task automatic rx_byte(input logic [7:0] b);
    #1;
    bus.ps2_read    = 1'b1;
    bus.ps2_rx_data = b;
    @(posedge clk);
    #1;
    bus.ps2_read = 1'b0;
  endtask

  // keyboard responder
  initial begin
    rsp_t r;
    bus.ps2_read    = 1'b0;
    bus.ps2_rx_data = 8'h00;
    forever begin
      @(posedge clk);
      if (pq.size() > 0) begin
        r = pq.pop_front();
        if (r.en) begin
          if (r.pre) begin
            repeat (r.dly / 2) @(posedge clk);
            rx_byte(r.pb);
            repeat (r.dly - r.dly / 2 - 1) @(posedge clk);
          end else begin
            repeat (r.dly) @(posedge clk);
          end
          rx_byte(r.b);
        end
      end
    end
  end

  task automatic wait_gnt(input logic [1:0] exp, input bit drop);
    bit hit = 0;
    logic [1:0] g = 2'b00;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) begin
        hit = 1;
        g = bus.gnt;
      end
    end
    if (!hit) chk("gnt_tmo", bus.gnt, exp);
    else if (drop) begin
      @(posedge clk);
      #1 bus.req = bus.req & ~g;
    end
  endtask

  task automatic wait_done(input logic [1:0] exp);
    bit hit = 0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      @(negedge clk);
      hit = (bus.done != 2'b00);
    end
    if (!hit) chk("done_tmo", bus.done, exp);
  endtask

  task automatic drain();
    repeat (5) @(posedge clk);
    #1;
    chk("left_wr", wq.size(), 0);
    chk("left_done", dq.size(), 0);
    chk("left_gnt", gq.size(), 0);
    chk("left_scan", sq.size(), 0);
    rq.delete();
  endtask

  task automatic go0(input logic [7:0] c, input logic [7:0] p,
                     input logic hp, input logic [2:0] d);
    bus.cmd0       = c;
    bus.param0     = p;
    bus.has_param0 = hp;
    gq.push_back(2'b01);
    dq.push_back(d);
    bus.req = 2'b01;
    wait_gnt(2'b01, 1'b1);
    wait_done(2'b01);
    drain();
  endtask

  initial begin
    rst_n = 1'b1;
    bus.req = 2'b00;
    bus.cmd0 = 8'h00;
    bus.cmd1 = 8'h00;
    bus.param0 = 8'h00;
    bus.param1 = 8'h00;
    bus.has_param0 = 1'b0;
    bus.has_param1 = 1'b0;
    bus.ps2_busy = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {bus.gnt, bus.done, bus.err, bus.ps2_write, bus.busy}, 0);
    chk("rst_tx", bus.ps2_tx_data, 0);
    chk("rst_scan", {bus.scan_valid, bus.scan_data}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // tie from reset: requester 0 first, then 1
    bus.cmd0 = CMD_ENABLE;
    bus.cmd1 = CMD_RESET;
    gq.push_back(2'b01);
    gq.push_back(2'b10);
    wq.push_back(CMD_ENABLE);
    wq.push_back(CMD_RESET);
    rq.push_back(mk(20, 1'b1, ACK));
    rq.push_back(mk(20, 1'b1, ACK));
    dq.push_back(3'b010);
    dq.push_back(3'b100);
    bus.req = 2'b11;
    wait_gnt(2'b01, 1'b1);
    wait_done(2'b01);
    wait_gnt(2'b10, 1'b1);
    wait_done(2'b10);
    drain();

    // both held: grants alternate
    for (int k = 0; k < 4; k++) begin
      gq.push_back(k[0] ? 2'b10 : 2'b01);
      wq.push_back(k[0] ? CMD_RESET : CMD_ENABLE);
      rq.push_back(mk(10, 1'b1, ACK));
      dq.push_back(k[0] ? 3'b100 : 3'b010);
    end
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(k[0] ? 2'b10 : 2'b01, 1'b0);
      wait_done(k[0] ? 2'b10 : 2'b01);
    end
    bus.req = 2'b00;
    drain();

    // single command, transceiver busy for a while first
    bus.cmd0 = CMD_ENABLE;
    bus.has_param0 = 1'b0;
    bus.ps2_busy = 1'b1;
    gq.push_back(2'b01);
    wq.push_back(CMD_ENABLE);
    rq.push_back(mk(500, 1'b1, ACK));
    dq.push_back(3'b010);
    bus.req = 2'b01;
    wait_gnt(2'b01, 1'b1);
    repeat (20) @(posedge clk);
    #1 bus.ps2_busy = 1'b0;
    wait_done(2'b01);
    drain();

    // command + parameter
    wq.push_back(CMD_SET_LEDS);
    wq.push_back(8'h04);
    rq.push_back(mk(30, 1'b1, ACK));
    rq.push_back(mk(30, 1'b1, ACK));
    go0(CMD_SET_LEDS, 8'h04, 1'b1, 3'b010);

    // param resend then ACK
    wq.push_back(CMD_SET_LEDS);
    repeat (2) wq.push_back(8'h04);
    rq.push_back(mk(30, 1'b1, ACK));
    rq.push_back(mk(30, 1'b1, RESEND));
    rq.push_back(mk(30, 1'b1, ACK));
    go0(CMD_SET_LEDS, 8'h04, 1'b1, 3'b010);

    // param resend exhausted
    wq.push_back(CMD_SET_LEDS);
    repeat (3) wq.push_back(8'h04);
    rq.push_back(mk(30, 1'b1, ACK));
    repeat (3) rq.push_back(mk(30, 1'b1, RESEND));
    go0(CMD_SET_LEDS, 8'h04, 1'b1, 3'b011);

    // no response: timeout retries
    gap_chk = 1;
    repeat (3) wq.push_back(CMD_ENABLE);
    repeat (3) rq.push_back(mk(0, 1'b0, 8'h00));
    go0(CMD_ENABLE, 8'h00, 1'b0, 3'b011);
    gap_chk = 0;

    // keyboard error: no retry
    wq.push_back(CMD_ENABLE);
    rq.push_back(mk(40, 1'b1, KBD_ERROR));
    go0(CMD_ENABLE, 8'h00, 1'b0, 3'b011);

    // ACK on the expiry cycle wins
    wq.push_back(CMD_ENABLE);
    rq.push_back(mk(TO - 1, 1'b1, ACK));
    go0(CMD_ENABLE, 8'h00, 1'b0, 3'b010);

    // scan byte during the wait is forwarded, ACK is not
    wq.push_back(CMD_ENABLE);
    tmp = mk(400, 1'b1, ACK);
    tmp.pre = 1'b1;
    tmp.pb = 8'h1C;
    rq.push_back(tmp);
    sq.push_back(8'h1C);
    go0(CMD_ENABLE, 8'h00, 1'b0, 3'b010);

    // idle forwards everything, response bytes included
    sq.push_back(SELF_TEST);
    sq.push_back(ACK);
    pq.push_back(mk(2, 1'b1, SELF_TEST));
    pq.push_back(mk(2, 1'b1, ACK));
    repeat (20) @(posedge clk);
    drain();

    // reset while waiting for the parameter ACK
    bus.cmd0 = CMD_SET_LEDS;
    bus.param0 = 8'h04;
    bus.has_param0 = 1'b1;
    gq.push_back(2'b01);
    wq.push_back(CMD_SET_LEDS);
    wq.push_back(8'h04);
    rq.push_back(mk(30, 1'b1, ACK));
    rq.push_back(mk(0, 1'b0, 8'h00));
    bus.req = 2'b01;
    wait_gnt(2'b01, 1'b1);
    for (int i = 0; i < 500 && wq.size() > 0; i++) @(posedge clk);
    repeat (50) @(posedge clk);
    #1;
    chk("mid_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {bus.gnt, bus.done, bus.err, bus.ps2_write, bus.busy}, 0);
    chk("mid_rst_tx", bus.ps2_tx_data, 0);
    chk("mid_rst_scan", {bus.scan_valid, bus.scan_data}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drain();

    bus.cmd1 = CMD_ENABLE;
    bus.has_param1 = 1'b0;
    gq.push_back(2'b10);
    wq.push_back(CMD_ENABLE);
    rq.push_back(mk(25, 1'b1, ACK));
    dq.push_back(3'b100);
    bus.req = 2'b10;
    wait_gnt(2'b10, 1'b1);
    wait_done(2'b10);
    drain();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
